// File: rtl/eth_rx_frame_parser.sv
// Ethernet rx frame parser: strips preamble/SFD, extracts dst/src/EtherType and
// forwards payload minus the 4-byte FCS. Optional macro ETH_DST_FILTER_EN drops foreign dst MACs.
module eth_rx_frame_parser #(
  parameter int unsigned MIN_PREAMBLE    = 7,
  parameter int unsigned IDLE_GAP_CYCLES = 6
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic [7:0]  dataIn,
  input  logic        dataValidIn,
  output logic [47:0] dstMacOut,
  output logic [47:0] srcMacOut,
  output logic [15:0] etherTypeOut,
  output logic        hdrValidOut,
  output logic [7:0]  payloadDataOut,
  output logic        payloadValidOut,
  output logic        payloadFirstOut,
  output logic        payloadLastOut,
  output logic        frameErrOut,
  output logic [15:0] frameCountOut
);
  localparam int unsigned GAP_W     = 8;
  localparam int unsigned FCS_DEPTH = 5;
  localparam logic [3:0]       MIN_PRE  = 4'(MIN_PREAMBLE);
  localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(IDLE_GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP_CYCLES - 1);
`ifdef ETH_DST_FILTER_EN
  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

  state_t           r_state, w_state_nxt;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [3:0]       r_pre_cnt, r_hdr_cnt;
  logic [103:0]     r_hdr_sh;
  logic [7:0]       r_fcs_buf [FCS_DEPTH];
  logic [2:0]       r_fcs_cnt;
  logic             r_first_pend;
  logic [47:0]      r_dst, r_src;
  logic [15:0]      r_type, r_frame_cnt;
  logic [7:0]       r_pay_data;
  logic             r_hdr_valid, r_pay_valid, r_pay_first, r_pay_last, r_frame_err;

  logic         w_gap_event, w_buf_full, w_dst_ok;
  logic         w_err, w_hdr_done, w_emit, w_last;
  logic [111:0] w_hdr_full;

  assign w_gap_event = !dataValidIn && (r_gap_cnt == GAP_LAST) && (r_state != S_IDLE);
  assign w_buf_full  = (r_fcs_cnt == 3'(FCS_DEPTH));
  assign w_hdr_full  = {r_hdr_sh, dataIn};

`ifdef ETH_DST_FILTER_EN
  assign w_dst_ok = (w_hdr_full[111:64] == LOCAL_MAC) || (w_hdr_full[111:64] == 48'hFFFF_FFFF_FFFF);
`else
  assign w_dst_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clkIn) begin
    if (rstIn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_hdr_done  = 1'b0;
    w_emit      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dataValidIn) begin
          if (dataIn == 8'h55) begin
            w_state_nxt = S_PREAMBLE;
          end else begin
            w_state_nxt = S_DROP;
            w_err       = 1'b1;
          end
        end
      end
      S_PREAMBLE: begin
        if (dataValidIn) begin
          if (dataIn == 8'hD5 && r_pre_cnt >= MIN_PRE) begin
            w_state_nxt = S_HEADER;
          end else if (dataIn != 8'h55) begin
            w_state_nxt = S_DROP;
            w_err       = 1'b1;
          end
        end else if (w_gap_event) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
      S_HEADER: begin
        if (dataValidIn) begin
          if (r_hdr_cnt == 4'd13) begin
            w_hdr_done  = w_dst_ok;
            w_state_nxt = w_dst_ok ? S_PAYLOAD : S_DROP;
          end
        end else if (w_gap_event) begin
          w_state_nxt = S_IDLE;
          w_err       = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (dataValidIn) begin
          w_emit = w_buf_full;
        end else if (w_gap_event) begin
          w_state_nxt = S_IDLE;
          w_emit      = w_buf_full;
          w_last      = w_buf_full;
          w_err       = !w_buf_full;
        end
      end
      S_DROP: begin
        if (w_gap_event) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: gap/preamble/header counters, FCS delay line, registered outputs
  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      r_gap_cnt    <= '0;
      r_pre_cnt    <= '0;
      r_hdr_cnt    <= '0;
      r_hdr_sh     <= '0;
      r_fcs_cnt    <= '0;
      r_first_pend <= 1'b0;
      for (int i = 0; i < FCS_DEPTH; i++) r_fcs_buf[i] <= '0;
      r_dst        <= '0;
      r_src        <= '0;
      r_type       <= '0;
      r_frame_cnt  <= '0;
      r_pay_data   <= '0;
      r_hdr_valid  <= 1'b0;
      r_pay_valid  <= 1'b0;
      r_pay_first  <= 1'b0;
      r_pay_last   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      if (dataValidIn)              r_gap_cnt <= '0;
      else if (r_gap_cnt != GAP_MAX) r_gap_cnt <= r_gap_cnt + GAP_W'(1);

      if (dataValidIn && dataIn == 8'h55) begin
        if (r_state == S_IDLE)                             r_pre_cnt <= 4'd1;
        else if (r_state == S_PREAMBLE && r_pre_cnt != 4'hF) r_pre_cnt <= r_pre_cnt + 4'd1;
      end

      if (r_state != S_HEADER) begin
        r_hdr_cnt <= '0;
      end else if (dataValidIn) begin
        r_hdr_cnt <= r_hdr_cnt + 4'd1;
        r_hdr_sh  <= w_hdr_full[103:0];
      end

      if (w_hdr_done) begin
        r_fcs_cnt    <= '0;
        r_first_pend <= 1'b1;
        r_dst        <= w_hdr_full[111:64];
        r_src        <= w_hdr_full[63:16];
        r_type       <= w_hdr_full[15:0];
      end else if (r_state == S_PAYLOAD && dataValidIn) begin
        r_fcs_buf[0] <= dataIn;
        for (int i = 1; i < FCS_DEPTH; i++) r_fcs_buf[i] <= r_fcs_buf[i-1];
        if (!w_buf_full) r_fcs_cnt <= r_fcs_cnt + 3'd1;
      end

      // Oldest buffered byte is released; the 4 newer ones are FCS at frame end
      if (w_emit) begin
        r_pay_data   <= r_fcs_buf[FCS_DEPTH-1];
        r_first_pend <= 1'b0;
      end
      r_pay_valid <= w_emit;
      r_pay_first <= w_emit && r_first_pend;
      r_pay_last  <= w_last;
      r_hdr_valid <= w_hdr_done;
      r_frame_err <= w_err;
      if (w_last) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign dstMacOut       = r_dst;
  assign srcMacOut       = r_src;
  assign etherTypeOut    = r_type;
  assign hdrValidOut     = r_hdr_valid;
  assign payloadDataOut  = r_pay_data;
  assign payloadValidOut = r_pay_valid;
  assign payloadFirstOut = r_pay_first;
  assign payloadLastOut  = r_pay_last;
  assign frameErrOut     = r_frame_err;
  assign frameCountOut   = r_frame_cnt;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Bench for eth_rx_frame_parser: byte streams with random bubbles, checked against a
// frame-level parse model of the expected headers, payload bytes and error pulses.
module tb_eth_rx_frame_parser;
  localparam int unsigned MIN_PRE  = 7;
  localparam int unsigned IDLE_GAP = 6;
  localparam int unsigned END_BUB  = IDLE_GAP + 4;
  localparam logic [47:0] LOCAL    = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC      = 48'hAA_BB_CC_DD_EE_FF;

  typedef logic [7:0] u8;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic [7:0]  dataIn = '0;
  logic        dataValidIn = 1'b0;
  logic [47:0] dstMacOut, srcMacOut;
  logic [15:0] etherTypeOut, frameCountOut;
  logic        hdrValidOut, payloadValidOut, payloadFirstOut, payloadLastOut, frameErrOut;
  logic [7:0]  payloadDataOut;

  eth_rx_frame_parser #(.MIN_PREAMBLE(MIN_PRE), .IDLE_GAP_CYCLES(IDLE_GAP)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
    .dstMacOut(dstMacOut), .srcMacOut(srcMacOut), .etherTypeOut(etherTypeOut),
    .hdrValidOut(hdrValidOut), .payloadDataOut(payloadDataOut),
    .payloadValidOut(payloadValidOut), .payloadFirstOut(payloadFirstOut),
    .payloadLastOut(payloadLastOut), .frameErrOut(frameErrOut),
    .frameCountOut(frameCountOut)
  );

  always #2 clkIn = ~clkIn;

  int n_checks = 0;
  int n_errors = 0;

  u8            g_bytes[$];
  int           g_bub[$];
  logic [111:0] e_hdr[$], m_hdr[$];
  logic [9:0]   e_pay[$], m_pay[$];
  int           e_err, m_err;
  logic [47:0]  e_dst = '0, e_src = '0;
  logic [15:0]  e_type = '0, e_cnt = '0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clkIn) begin
    if (!rstIn) begin
      if (hdrValidOut)     m_hdr.push_back({dstMacOut, srcMacOut, etherTypeOut});
      if (payloadValidOut) m_pay.push_back({payloadFirstOut, payloadLastOut, payloadDataOut});
      if (frameErrOut)     m_err++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic drive(input logic v, input u8 d);
    dataValidIn = v;
    dataIn      = d;
    @(posedge clkIn);
    #1;
  endtask

  task automatic push(input u8 b);
    g_bytes.push_back(b);
    g_bub.push_back(int'($urandom_range(1, 2)));
  endtask

  task automatic add_frame(input int npre, input logic [47:0] dst, input logic [47:0] src,
                           input logic [15:0] typ, input int hdr_n, input int npay,
                           input int nfcs, input int end_bub);
    logic [111:0] h;
    h = {dst, src, typ};
    for (int i = 0; i < npre; i++) push(8'h55);
    push(8'hD5);
    for (int j = 0; j < hdr_n; j++) push(h[111 - 8*j -: 8]);
    if (hdr_n == 14) begin
      for (int k = 0; k < npay; k++) push(u8'(k));
      for (int k = 0; k < nfcs; k++) push(u8'($urandom));
    end
    g_bub[g_bub.size() - 1] = end_bub;
  endtask

  // Reference parse of one gap-delimited segment g_bytes[a..b-1]
  task automatic model_seg(input int a, input int b);
    int i, n, r;
    logic [111:0] h;
    logic ok;
    if (b <= a) return;
    if (g_bytes[a] != 8'h55) begin e_err++; return; end
    i = a; n = 0;
    while (i < b && g_bytes[i] == 8'h55) begin n++; i++; end
    if (i == b || g_bytes[i] != 8'hD5 || n < int'(MIN_PRE)) begin e_err++; return; end
    i++;
    if (b - i < 14) begin e_err++; return; end
    h = '0;
    for (int j = 0; j < 14; j++) h = {h[103:0], g_bytes[i + j]};
    i += 14;
`ifdef ETH_DST_FILTER_EN
    ok = (h[111:64] == LOCAL) || (h[111:64] == 48'hFFFF_FFFF_FFFF);
`else
    ok = 1'b1;
`endif
    if (!ok) return;
    e_hdr.push_back(h);
    e_dst = h[111:64]; e_src = h[63:16]; e_type = h[15:0];
    r = b - i;
    if (r < 5) begin e_err++; return; end
    for (int k = 0; k <= r - 5; k++)
      e_pay.push_back({(k == 0), (k == r - 5), g_bytes[i + k]});
    e_cnt = e_cnt + 16'd1;
  endtask

  task automatic run_case(input string tag);
    int start, n;
    e_hdr.delete(); e_pay.delete(); e_err = 0;
    start = 0;
    for (int i = 0; i < g_bytes.size(); i++) begin
      if (g_bub[i] >= int'(IDLE_GAP) || i == g_bytes.size() - 1) begin
        model_seg(start, i + 1);
        start = i + 1;
      end
    end
    m_hdr.delete(); m_pay.delete(); m_err = 0;
    for (int i = 0; i < g_bytes.size(); i++) begin
      drive(1'b1, g_bytes[i]);
      repeat (g_bub[i]) drive(1'b0, 8'h00);
    end
    check_eq({tag, "_hdr_n"}, 128'(m_hdr.size()), 128'(e_hdr.size()));
    n = (m_hdr.size() < e_hdr.size()) ? m_hdr.size() : e_hdr.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_hdr"}, 128'(m_hdr[i]), 128'(e_hdr[i]));
    check_eq({tag, "_pay_n"}, 128'(m_pay.size()), 128'(e_pay.size()));
    n = (m_pay.size() < e_pay.size()) ? m_pay.size() : e_pay.size();
    for (int i = 0; i < n; i++) check_eq({tag, "_pay"}, 128'(m_pay[i]), 128'(e_pay[i]));
    check_eq({tag, "_err_n"}, 128'(m_err), 128'(e_err));
    check_eq({tag, "_fields"}, 128'({dstMacOut, srcMacOut, etherTypeOut}),
             128'({e_dst, e_src, e_type}));
    check_eq({tag, "_count"}, 128'(frameCountOut), 128'(e_cnt));
    g_bytes.delete(); g_bub.delete();
  endtask

  initial begin
    int sel, npre, hdr_n, npay, bub;
    logic [47:0] dst;
    repeat (3) @(posedge clkIn);
    #1;
    check_eq("rst_fields", 128'({dstMacOut, srcMacOut, etherTypeOut}), 128'(0));
    check_eq("rst_ctrl", 128'({hdrValidOut, payloadDataOut, payloadValidOut, payloadFirstOut,
                               payloadLastOut, frameErrOut, frameCountOut}), 128'(0));
    rstIn = 1'b0;
    repeat (4) drive(1'b0, 8'h00);

    add_frame(7, LOCAL, SRC, 16'h0800, 14, 64, 4, END_BUB);
    run_case("good");
    add_frame(7, LOCAL, SRC, 16'h86DD, 14, 10, 4, IDLE_GAP);
    add_frame(8, 48'hFFFF_FFFF_FFFF, SRC, 16'h0806, 14, 12, 4, END_BUB);
    run_case("b2b_exact");
    add_frame(7, LOCAL, SRC, 16'h0800, 14, 8, 4, IDLE_GAP - 1);
    add_frame(7, LOCAL, SRC, 16'h0801, 14, 6, 4, END_BUB);
    run_case("b2b_merge");
    add_frame(3, LOCAL, SRC, 16'h0800, 14, 8, 4, END_BUB);
    run_case("bad_pre");
    add_frame(7, LOCAL, 48'h1122_3344_5566, 16'h1234, 14, 16, 4, END_BUB);
    run_case("after_bad");
    add_frame(7, 48'h0A0B_0C0D_0E0F, SRC, 16'h0800, 9, 0, 0, END_BUB);
    run_case("runt_hdr");
    add_frame(7, LOCAL, SRC, 16'h0800, 14, 0, 4, END_BUB);
    run_case("runt_4");
    add_frame(7, LOCAL, SRC, 16'h0800, 14, 1, 4, END_BUB);
    run_case("runt_5");
    add_frame(7, 48'h02_00_00_00_00_02, SRC, 16'h0800, 14, 6, 4, END_BUB);
    run_case("dst_other");
    add_frame(7, 48'hFFFF_FFFF_FFFF, SRC, 16'h0800, 14, 6, 4, END_BUB);
    run_case("dst_bcast");

    // Reset lands together with payload byte 20
    add_frame(7, LOCAL, SRC, 16'h0800, 14, 64, 4, END_BUB);
    for (int i = 0; i < 42; i++) begin
      drive(1'b1, g_bytes[i]);
      repeat (g_bub[i]) drive(1'b0, 8'h00);
    end
    rstIn = 1'b1;
    drive(1'b1, g_bytes[42]);
    drive(1'b0, 8'h00);
    check_eq("midrst_fields", 128'({dstMacOut, srcMacOut, etherTypeOut}), 128'(0));
    check_eq("midrst_ctrl", 128'({hdrValidOut, payloadDataOut, payloadValidOut, payloadFirstOut,
                                  payloadLastOut, frameErrOut, frameCountOut}), 128'(0));
    rstIn = 1'b0;
    for (int i = 0; i < 43; i++) begin
      void'(g_bytes.pop_front());
      void'(g_bub.pop_front());
    end
    e_dst = '0; e_src = '0; e_type = '0; e_cnt = '0;
    run_case("rst_tail");
    add_frame(7, LOCAL, SRC, 16'h0800, 14, 20, 4, END_BUB);
    run_case("after_rst");

    for (int it = 0; it < 12; it++) begin
      sel   = int'($urandom_range(0, 2));
      dst   = (sel == 0) ? LOCAL : (sel == 1) ? 48'hFFFF_FFFF_FFFF : 48'({$urandom, $urandom});
      npre  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(7, 15));
      hdr_n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 13)) : 14;
      npay  = int'($urandom_range(0, 24));
      bub   = (it % 3 == 0) ? int'(IDLE_GAP) - int'($urandom_range(0, 1)) : int'(END_BUB);
      add_frame(npre, dst, 48'({$urandom, $urandom}), 16'($urandom), hdr_n, npay, 4, bub);
      if (it % 3 == 0)
        add_frame(7, LOCAL, SRC, 16'($urandom), 14, int'($urandom_range(1, 16)), 4, END_BUB);
      run_case("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/eth_rx_frame_parser.md
Name: eth_rx_frame_parser

Overview:
- Sits directly downstream of the 125->250 MHz rx CDC FIFO, in the 250 MHz domain.
- Consumes the FIFO's byte stream (data plus valid, never back-pressured).
- Strips preamble/SFD, extracts the Ethernet header (dst MAC, src MAC, EtherType), strips the 4-byte FCS and emits payload bytes with first/last markers to the message decoder.
- Frame end is detected by an idle gap, because the FIFO inserts bubbles and carries no end-of-frame flag.

Parameters:
- MIN_PREAMBLE, 7: minimum count of 0x55 bytes required before SFD 0xD5.
- IDLE_GAP_CYCLES, 6: consecutive clkIn cycles with dataValidIn=0 that terminate a frame. Must be at least 3, since valid arrives at most every 2nd cycle.
- LOCAL_MAC, 48'h02_00_00_00_00_01: accepted destination MAC; used only with ETH_DST_FILTER_EN.

Ports:
- clkIn  in  1  250 MHz clock
- rstIn  in  1  synchronous, active-high reset
- dataIn  in  8  byte from CDC FIFO
- dataValidIn  in  1  dataIn valid this cycle
- dstMacOut  out  48  destination MAC of current frame
- srcMacOut  out  48  source MAC of current frame
- etherTypeOut  out  16  EtherType, big-endian
- hdrValidOut  out  1  one-cycle pulse: header fields updated
- payloadDataOut  out  8  payload byte
- payloadValidOut  out  1  payloadDataOut valid
- payloadFirstOut  out  1  first payload byte of frame (qualified by valid)
- payloadLastOut  out  1  last payload byte of frame (qualified by valid)
- frameErrOut  out  1  one-cycle pulse: malformed frame
- frameCountOut  out  16  count of frames with payloadLastOut emitted; wraps at 0xFFFF->0

Behaviour:
- Reset: all outputs 0, state IDLE, preamble/header counters 0, gap counter 0, FCS buffer empty. Reset asserted mid-frame discards the frame with no last and no error. Bytes arriving after reset release are parsed from IDLE.
- Gap counter: increments each cycle dataValidIn=0, saturating at IDLE_GAP_CYCLES. Clears on any valid byte. A "gap event" is the cycle it reaches IDLE_GAP_CYCLES while the state is not IDLE.
- IDLE:
  - 0x55 -> PREAMBLE with count=1.
  - Any other valid byte -> DROP with frameErrOut pulse.
- PREAMBLE:
  - 0x55 -> count++, saturating at 15.
  - 0xD5 with count>=MIN_PREAMBLE -> HEADER.
  - 0xD5 with count<MIN_PREAMBLE, or any other byte -> DROP with frameErrOut.
  - Gap event -> IDLE with frameErrOut.
- HEADER:
  - 14 bytes shift in MSB-first: bytes 0-5 dst, 6-11 src, 12-13 EtherType.
  - Output fields update, and hdrValidOut pulses, the cycle after byte 13 is accepted. State -> PAYLOAD.
  - Gap event before byte 13 -> IDLE with frameErrOut. Output fields keep their previous values.
- PAYLOAD:
  - Each byte enters a 5-entry FCS delay buffer.
  - When a byte is accepted with the buffer already holding 5, the oldest byte is output the next cycle with payloadValidOut=1. The first such byte has payloadFirstOut=1.
  - Steady-state latency: byte k appears 1 cycle after byte k+5 is accepted.
  - Gap event with buffer holding 5: next cycle, output oldest byte with payloadLastOut=1; discard the remaining 4 (FCS); frameCountOut++; -> IDLE.
  - If that byte is the frame's only payload byte, first and last are both 1.
  - Gap event with buffer holding fewer than 5 (no payload bytes) -> IDLE with frameErrOut, nothing emitted.
- DROP: ignore bytes; gap event -> IDLE with no extra error pulse.
- Payload byte count is unbounded; no length field is checked. FCS is not verified.
- payloadValidOut is never asserted more than once per accepted input byte. Bubbles pass through.

Optional Feature:
- ETH_DST_FILTER_EN defined: at header completion, dstMac is compared against LOCAL_MAC and 48'hFFFF_FFFF_FFFF.
  - Match: behaviour as above.
  - Mismatch: -> DROP, no hdrValidOut, no payload, no frameErrOut; frameCountOut unchanged.
- ETH_DST_FILTER_EN undefined: all well-formed frames are accepted and LOCAL_MAC is unused.

Test Plan:
- Good frame: 7x55, D5, dst 02_00_00_00_00_01, src AA_BB_CC_DD_EE_FF, type 0800, payload 00..3F (64 B), 4 FCS bytes, fed valid every 2nd cycle -> hdrValidOut once with matching fields; 64 payload bytes in order 00..3F; first on 00, last on 3F; no FCS bytes output; frameCountOut=1.
- Back-to-back frames separated by exactly IDLE_GAP_CYCLES idle cycles -> two complete frames, frameCountOut=2. Separated by IDLE_GAP_CYCLES-1 -> bytes merge into the first frame's payload.
- Bad preamble: 3x55 then D5 -> frameErrOut pulse, no hdrValidOut, no payload; the next good frame parses correctly.
- Runt frames:
  - Gap after header byte 8 -> frameErrOut, header outputs unchanged.
  - Header plus 4 bytes -> frameErrOut, no payload.
  - Header plus 5 bytes -> a single byte with first=last=1.
- Reset asserted during payload byte 20, then released -> all outputs 0, no last emitted; the remaining tail bytes give frameErrOut once; the following frame parses correctly.
- With ETH_DST_FILTER_EN:
  - dst 02_00_00_00_00_02 -> no hdrValidOut/payload/error.
  - dst FF..FF -> accepted.
  - Without the macro, the same 02..02 frame is accepted.
